// File: rtl/funct_generator_pkg.sv
// Shared types and default sizes for the function generator controller.
package funct_generator_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONFI = 2'd1,
        GEN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    typedef enum logic {
        MODE_CONT    = 1'b0,
        MODE_ONESHOT = 1'b1
    } mode_t;

    localparam int NUM_CH_DEF = 2;
    localparam int DEPTH_DEF  = 256;
    localparam int DIV_W_DEF  = 16;

endpackage

// File: rtl/funct_generator_chan.sv
// One waveform-address channel: rate prescaler, address counter,
// per-channel divider/mode configuration, wrap pulse and sticky done.
module funct_generator_chan
    import funct_generator_pkg::*;
#(
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              run,
    input  logic              cfg_we,
    input  logic [DIV_W-1:0]  cfg_div,
    input  mode_t             cfg_mode,
    input  logic              clr,
    output logic [ADDR_W-1:0] addr_o,
    output logic              wrap_o,
    output logic              done_o
);

    localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

    logic [DIV_W-1:0]  div_q,   div_d;
    logic [DIV_W-1:0]  presc_q, presc_d;
    mode_t             mode_q,  mode_d;
    logic [ADDR_W-1:0] addr_q,  addr_d;
    logic              wrap_q,  wrap_d;
    logic              done_q,  done_d;

    // Next-state: config write beats clear beats counting; wrap is a single-cycle pulse.
    always_comb begin
        div_d   = div_q;
        mode_d  = mode_q;
        presc_d = presc_q;
        addr_d  = addr_q;
        done_d  = done_q;
        wrap_d  = 1'b0;
        if (cfg_we) begin
            div_d   = cfg_div;
            mode_d  = cfg_mode;
            presc_d = '0;
            addr_d  = '0;
            done_d  = 1'b0;
        end else if (clr) begin
            presc_d = '0;
            addr_d  = '0;
            done_d  = 1'b0;
        end else if (run && !done_q) begin
            if (presc_q == div_q) begin
                presc_d = '0;
                if (mode_q == MODE_CONT) begin
                    if (addr_q == LAST) begin
                        addr_d = '0;
                        wrap_d = 1'b1;
                    end else begin
                        addr_d = addr_q + ADDR_W'(1);
                    end
                end else if (addr_q != LAST) begin
                    addr_d = addr_q + ADDR_W'(1);
                    done_d = ((addr_q + ADDR_W'(1)) == LAST);
                end
            end else begin
                presc_d = presc_q + DIV_W'(1);
            end
        end
    end

    // Channel state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst) begin
            div_q   <= '0;
            mode_q  <= MODE_CONT;
            presc_q <= '0;
            addr_q  <= '0;
            wrap_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            div_q   <= div_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            addr_q  <= addr_d;
            wrap_q  <= wrap_d;
            done_q  <= done_d;
        end
    end

    assign addr_o = addr_q;
    assign wrap_o = wrap_q;
    assign done_o = done_q;

endmodule

// File: rtl/funct_generator_ctrl.sv
// Multi-channel function generator controller: one shared sequencing FSM
// over NUM_CH independent address channels, configured by valid/ready words.
module funct_generator_ctrl
    import funct_generator_pkg::*;
#(
    parameter int NUM_CH = NUM_CH_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int ADDR_W = $clog2(DEPTH),
    parameter int DIV_W  = DIV_W_DEF
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  logic                                       en_low_i,
    input  logic                                       conf_valid_i,
    output logic                                       conf_ready_o,
    input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] conf_ch_i,
    input  logic [DIV_W-1:0]                           conf_div_i,
    input  logic                                       conf_mode_i,
    output logic [NUM_CH*ADDR_W-1:0]                   addr_o,
    output logic [NUM_CH-1:0]                          gen_en_o,
    output logic [NUM_CH-1:0]                          wrap_o,
    output logic [NUM_CH-1:0]                          done_o,
    output logic                                       busy_o
);

    localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    state_t            state_q,  state_d;
    logic [NUM_CH-1:0] gen_en_q, gen_en_d;
    logic              busy_q,   busy_d;
    logic              ready_q,  ready_d;

    logic [NUM_CH-1:0] chan_done;
    logic              all_done;
    logic              run;
    logic              clr;
    logic              accept;

    assign all_done = &chan_done;

    // Next state and registered outputs decoded from it; a pending config word always wins.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (conf_valid_i)   state_d = CONFI;
                else if (!en_low_i) state_d = GEN;
            end
            CONFI: begin
                if (conf_valid_i)   state_d = CONFI;
                else if (!en_low_i) state_d = GEN;
                else                state_d = IDLE;
            end
            GEN: begin
                if (conf_valid_i)  state_d = CONFI;
                else if (en_low_i) state_d = IDLE;
                else if (all_done) state_d = DONE;
            end
            DONE: begin
                if (conf_valid_i)  state_d = CONFI;
                else if (en_low_i) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d   = (state_d == GEN);
        ready_d  = (state_d == CONFI);
        gen_en_d = (state_d == GEN) ? ~chan_done : '0;
    end

    // FSM state and control output registers.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q  <= IDLE;
            gen_en_q <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            gen_en_q <= gen_en_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
        end
    end

    // Channels advance only while GEN persists, so entering GEN and pausing both freeze addresses.
    assign run    = (state_q == GEN) && (state_d == GEN);
    assign clr    = (state_d == IDLE);
    assign accept = ready_q && conf_valid_i;

    for (genvar c = 0; c < NUM_CH; c++) begin : g_chan
        funct_generator_chan #(
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W),
            .DIV_W  (DIV_W)
        ) u_chan (
            .clk      (clk),
            .rst      (rst),
            .run      (run),
            .cfg_we   (accept && (conf_ch_i == CH_W'(c))),
            .cfg_div  (conf_div_i),
            .cfg_mode (mode_t'(conf_mode_i)),
            .clr      (clr),
            .addr_o   (addr_o[c*ADDR_W +: ADDR_W]),
            .wrap_o   (wrap_o[c]),
            .done_o   (chan_done[c])
        );
    end

    assign conf_ready_o = ready_q;
    assign gen_en_o     = gen_en_q;
    assign busy_o       = busy_q;
    assign done_o       = chan_done;

endmodule

// File: tb/tb_funct_generator_ctrl.sv
// Bench for funct_generator_ctrl: directed scenarios plus random traffic,
// each cycle's expected outputs queued by a reference model and popped by a monitor.
module tb_funct_generator_ctrl;

    localparam int NUM_CH = 3;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;
    localparam int DIV_W  = 16;
    localparam int CH_W   = 2;

    localparam int S_IDLE = 0;
    localparam int S_CONF = 1;
    localparam int S_GEN  = 2;
    localparam int S_DONE = 3;

    logic                     clk = 1'b0;
    logic                     rst;
    logic                     en_low_i;
    logic                     conf_valid_i;
    logic                     conf_ready_o;
    logic [CH_W-1:0]          conf_ch_i;
    logic [DIV_W-1:0]         conf_div_i;
    logic                     conf_mode_i;
    logic [NUM_CH*ADDR_W-1:0] addr_o;
    logic [NUM_CH-1:0]        gen_en_o;
    logic [NUM_CH-1:0]        wrap_o;
    logic [NUM_CH-1:0]        done_o;
    logic                     busy_o;

    int checks   = 0;
    int failures = 0;
    int hs       = 0;
    int wraps    = 0;

    typedef struct packed {
        logic [NUM_CH*ADDR_W-1:0] addr;
        logic [NUM_CH-1:0]        gen_en;
        logic [NUM_CH-1:0]        wrap;
        logic [NUM_CH-1:0]        done;
        logic                     busy;
        logic                     ready;
    } out_t;

    out_t exp_q[$];

    // Reference model: each channel is described by how many running cycles it has seen.
    int m_st;
    int m_div [NUM_CH];
    bit m_os  [NUM_CH];
    int m_run [NUM_CH];

    always #5 clk = ~clk;

    funct_generator_ctrl #(
        .NUM_CH (NUM_CH),
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .DIV_W  (DIV_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .en_low_i     (en_low_i),
        .conf_valid_i (conf_valid_i),
        .conf_ready_o (conf_ready_o),
        .conf_ch_i    (conf_ch_i),
        .conf_div_i   (conf_div_i),
        .conf_mode_i  (conf_mode_i),
        .addr_o       (addr_o),
        .gen_en_o     (gen_en_o),
        .wrap_o       (wrap_o),
        .done_o       (done_o),
        .busy_o       (busy_o)
    );

    function automatic int m_ticks(int c);
        return m_run[c] / (m_div[c] + 1);
    endfunction

    function automatic int m_addr(int c);
        int t;
        t = m_ticks(c);
        if (m_os[c]) return (t > DEPTH - 1) ? DEPTH - 1 : t;
        return t % DEPTH;
    endfunction

    function automatic bit m_done(int c);
        return m_os[c] && (m_ticks(c) >= DEPTH - 1);
    endfunction

    function automatic int ch_addr(int c);
        return int'(addr_o[c*ADDR_W +: ADDR_W]);
    endfunction

    task automatic model_step();
        out_t              e;
        int                nst;
        bit                all_done;
        bit [NUM_CH-1:0]   done_prev;
        int                told [NUM_CH];
        int                ch;
        e = '0;
        if (!rst) begin
            m_st = S_IDLE;
            for (int c = 0; c < NUM_CH; c++) begin
                m_div[c] = 0;
                m_os[c]  = 1'b0;
                m_run[c] = 0;
            end
        end else begin
            all_done = 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                done_prev[c] = m_done(c);
                told[c]      = m_ticks(c);
                if (!done_prev[c]) all_done = 1'b0;
            end
            nst = m_st;
            if (conf_valid_i) nst = S_CONF;
            else begin
                case (m_st)
                    S_IDLE:  if (!en_low_i) nst = S_GEN;
                    S_CONF:  nst = en_low_i ? S_IDLE : S_GEN;
                    S_GEN:   if (en_low_i) nst = S_IDLE; else if (all_done) nst = S_DONE;
                    default: if (en_low_i) nst = S_IDLE;
                endcase
            end
            ch = int'(conf_ch_i);
            if (m_st == S_CONF && conf_valid_i) begin
                if (ch < NUM_CH) begin
                    m_div[ch] = int'(conf_div_i);
                    m_os[ch]  = conf_mode_i;
                    m_run[ch] = 0;
                end
            end else if (nst == S_IDLE) begin
                for (int c = 0; c < NUM_CH; c++) m_run[c] = 0;
            end else if (m_st == S_GEN && nst == S_GEN) begin
                for (int c = 0; c < NUM_CH; c++) m_run[c]++;
            end
            for (int c = 0; c < NUM_CH; c++) begin
                e.addr[c*ADDR_W +: ADDR_W] = ADDR_W'(m_addr(c));
                e.done[c]   = m_done(c);
                e.wrap[c]   = !m_os[c] && (m_ticks(c) > told[c]) && (m_ticks(c) % DEPTH == 0);
                e.gen_en[c] = (nst == S_GEN) && !done_prev[c];
            end
            e.busy  = (nst == S_GEN);
            e.ready = (nst == S_CONF);
            m_st    = nst;
        end
        exp_q.push_back(e);
    endtask

    // One clock: the model sees the same inputs the DUT samples, then return at the falling edge.
    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input longint got, input longint req);
        checks++;
        if (got != req) begin
            failures++;
            $display("FAIL %s got=%0d required=%0d", name, got, req);
        end
    endtask

    task automatic send_cfg(input int ch, input int dv, input bit md);
        int guard;
        guard        = 0;
        conf_valid_i = 1'b1;
        conf_ch_i    = CH_W'(ch);
        conf_div_i   = DIV_W'(dv);
        conf_mode_i  = md;
        while (!conf_ready_o && guard < 8) begin
            tick();
            guard++;
        end
        check("cfg_ready", conf_ready_o, 1);
        tick();
        hs++;
    endtask

    // Scoreboard monitor: one expected output set per clock.
    initial begin
        out_t e;
        out_t g;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e        = exp_q.pop_front();
                g.addr   = addr_o;
                g.gen_en = gen_en_o;
                g.wrap   = wrap_o;
                g.done   = done_o;
                g.busy   = busy_o;
                g.ready  = conf_ready_o;
                checks++;
                if (g !== e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t got addr=%h en=%b wrap=%b done=%b busy=%b rdy=%b required addr=%h en=%b wrap=%b done=%b busy=%b rdy=%b",
                             $time, g.addr, g.gen_en, g.wrap, g.done, g.busy, g.ready,
                             e.addr, e.gen_en, e.wrap, e.done, e.busy, e.ready);
                end
            end
        end
    end

    initial begin
        rst          = 1'b0;
        en_low_i     = 1'b1;
        conf_valid_i = 1'b0;
        conf_ch_i    = '0;
        conf_div_i   = '0;
        conf_mode_i  = 1'b0;
        repeat (2) tick();
        rst = 1'b1;
        tick();
        check("rst_addr", addr_o, 0);
        check("rst_busy", busy_o, 0);
        check("rst_gen_en", gen_en_o, 0);
        check("rst_done", done_o, 0);
        check("rst_ready", conf_ready_o, 0);

        // Defaults: continuous, div 0, wrap once per DEPTH steps
        en_low_i = 1'b0;
        tick();
        check("t1_busy", busy_o, 1);
        check("t1_gen_en", gen_en_o, 3'b111);
        check("t1_addr_entry", ch_addr(0), 0);
        tick();
        check("t1_addr_first", ch_addr(0), 1);
        wraps = 0;
        repeat (255) begin
            tick();
            if (wrap_o[0]) wraps++;
        end
        check("t1_addr_wrapped", ch_addr(0), 0);
        check("t1_wrap_count", wraps, 1);

        // ch1 one-shot, div 3
        en_low_i = 1'b1;
        tick();
        check("t2_idle_addr", addr_o, 0);
        send_cfg(1, 3, 1'b1);
        conf_valid_i = 1'b0;
        en_low_i     = 1'b0;
        tick();
        check("t2_busy", busy_o, 1);
        repeat (1019) tick();
        check("t2_addr1_254", ch_addr(1), 254);
        check("t2_done_early", done_o[1], 0);
        tick();
        check("t2_addr1_255", ch_addr(1), 255);
        check("t2_done_set", done_o[1], 1);
        check("t2_gen_en_hold", gen_en_o[1], 1);
        tick();
        check("t2_gen_en_drop", gen_en_o[1], 0);
        check("t2_busy_still", busy_o, 1);
        check("t2_ch0_counting", ch_addr(0), 1021 % 256);

        // All channels one-shot div 0 -> DONE
        en_low_i = 1'b1;
        tick();
        send_cfg(0, 0, 1'b1);
        send_cfg(1, 0, 1'b1);
        send_cfg(2, 0, 1'b1);
        conf_valid_i = 1'b0;
        en_low_i     = 1'b0;
        tick();
        repeat (255) tick();
        check("t3_addr_all_last", addr_o, 24'hFFFFFF);
        check("t3_done_all", done_o, 3'b111);
        tick();
        check("t3_done_busy", busy_o, 0);
        check("t3_done_gen_en", gen_en_o, 0);
        check("t3_done_addr_held", addr_o, 24'hFFFFFF);
        en_low_i = 1'b1;
        tick();
        check("t3_idle_addr", addr_o, 0);
        check("t3_idle_done", done_o, 0);

        // Pause mid-GEN for a ch1 config word
        send_cfg(0, 0, 1'b0);
        conf_valid_i = 1'b0;
        en_low_i     = 1'b0;
        tick();
        repeat (40) tick();
        check("t4_addr0_40", ch_addr(0), 40);
        conf_valid_i = 1'b1;
        conf_ch_i    = CH_W'(1);
        conf_div_i   = DIV_W'(2);
        conf_mode_i  = 1'b0;
        tick();
        check("t4_ready", conf_ready_o, 1);
        check("t4_frozen_addr0", ch_addr(0), 40);
        check("t4_conf_gen_en", gen_en_o, 0);
        tick();
        conf_valid_i = 1'b0;
        tick();
        check("t4_resume_busy", busy_o, 1);
        check("t4_resume_addr1", ch_addr(1), 0);
        tick();
        check("t4_addr0_41", ch_addr(0), 41);
        check("t4_addr2_41", ch_addr(2), 41);
        check("t4_addr1_still0", ch_addr(1), 0);

        // Back-to-back words, one aimed at a non-existent channel
        en_low_i = 1'b1;
        tick();
        hs = 0;
        send_cfg(0, 1, 1'b0);
        send_cfg(1, 2, 1'b0);
        send_cfg(3, 5, 1'b0);
        check("t5_handshakes", hs, 3);
        conf_valid_i = 1'b0;
        en_low_i     = 1'b0;
        tick();
        repeat (6) tick();
        check("t5_addr0_div1", ch_addr(0), 3);
        check("t5_addr1_div2", ch_addr(1), 2);
        check("t5_addr2_untouched", ch_addr(2), 6);

        // Reset mid-GEN
        repeat (194) tick();
        check("t6_addr0_100", ch_addr(0), 100);
        rst = 1'b0;
        tick();
        check("t6_rst_addr", addr_o, 0);
        check("t6_rst_busy", busy_o, 0);
        check("t6_rst_gen_en", gen_en_o, 0);
        check("t6_rst_done", done_o, 0);
        rst = 1'b1;
        tick();
        check("t6_regen_busy", busy_o, 1);
        tick();
        check("t6_div_default", addr_o, 24'h010101);
        repeat (255) tick();
        check("t6_mode_default_addr", addr_o, 0);
        check("t6_mode_default_wrap", wrap_o, 3'b111);

        // Random traffic against the model
        repeat (6000) begin
            rst          = ($urandom_range(0, 999) != 0);
            conf_valid_i = ($urandom_range(0, 39) == 0);
            en_low_i     = ($urandom_range(0, 399) == 0);
            conf_ch_i    = CH_W'($urandom_range(0, 3));
            conf_div_i   = DIV_W'($urandom_range(0, 1));
            conf_mode_i  = 1'($urandom_range(0, 1));
            tick();
        end
        rst          = 1'b1;
        conf_valid_i = 1'b0;
        repeat (2) tick();
        @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/funct_generator_ctrl.md
Name: funct_generator_ctrl

Overview:
Parametrised multi-channel controller for the function generator datapath.
- One shared FSM (IDLE/CONFI/GEN/DONE) sequences NUM_CH waveform-address channels.
- Each channel has its own rate divider and mode: continuous or one-shot.
- Configuration arrives through a valid/ready handshake. Addresses drive the per-channel waveform ROM/LUT read ports.

Parameters:
NUM_CH, 2, number of independent generator channels (>=1)
DEPTH, 256, waveform table length per channel (>=2)
ADDR_W, $clog2(DEPTH), address width per channel
DIV_W, 16, rate-divider width; a channel steps once every div+1 cycles

Ports:
clk  in  1  system clock
rst  in  1  reset
en_low_i  in  1  active-low generate enable
conf_valid_i  in  1  configuration word valid
conf_ready_o  out  1  configuration accepted when valid&ready
conf_ch_i  in  max(1,$clog2(NUM_CH))  target channel of configuration word
conf_div_i  in  DIV_W  rate divider value
conf_mode_i  in  1  0=continuous (wrap), 1=one-shot (stop at DEPTH-1)
addr_o  out  NUM_CH*ADDR_W  packed channel addresses, channel 0 in LSBs
gen_en_o  out  NUM_CH  per-channel generate/read enable
wrap_o  out  NUM_CH  one-cycle pulse when a continuous channel wraps to 0
done_o  out  NUM_CH  sticky; one-shot channel reached DEPTH-1
busy_o  out  1  high in GEN

Behaviour:
Reset and clock:
- One clock; reset is synchronous and active-low (rst=0 sampled at posedge clk resets).
- On reset: state=IDLE; all outputs 0; all div regs=0; all modes=continuous; all addresses and prescalers=0.
- All outputs are registered. Outputs are decoded from next state, so they align with the state they describe.

FSM. Priority in every state is conf_valid_i > en_low_i.
- IDLE: addresses and prescalers held at 0; done cleared.
  - conf_valid_i -> CONFI.
  - Else en_low_i=0 -> GEN.
  - Else stay in IDLE.
- CONFI: conf_ready_o=1; gen_en_o=0; channels frozen.
  - On each valid&ready: write div and mode of channel conf_ch_i, clear its address, prescaler and done.
  - Back-to-back words are accepted one per cycle.
  - conf_valid_i=0 -> GEN if en_low_i=0, else IDLE.
  - conf_ch_i >= NUM_CH: word is accepted and discarded.
- GEN: busy_o=1; gen_en_o[c]=1 for every channel not done.
  - conf_valid_i -> CONFI (pause; unconfigured channels keep address and prescaler).
  - Else en_low_i=1 -> IDLE (all channels cleared).
  - Else all channels done -> DONE.
  - Otherwise stay in GEN.
- DONE: gen_en_o=0, busy_o=0; addresses and done_o held.
  - conf_valid_i -> CONFI.
  - Else en_low_i=1 -> IDLE.
- Illegal state encoding -> IDLE.

Channel counting (GEN only):
- Prescaler counts 0..div; tick when prescaler==div, then prescaler returns to 0. div=0 gives a tick every cycle.
- On tick, continuous mode: address increments; DEPTH-1 -> 0 with wrap_o pulsed in the same cycle addr_o shows 0.
- On tick, one-shot mode: address increments up to DEPTH-1.
  - The tick that lands on DEPTH-1 sets done_o in the same cycle addr_o shows DEPTH-1.
  - gen_en_o[c] drops the cycle after done_o rises.
  - Address holds at DEPTH-1.
- Continuous channels never set done. DONE is therefore reachable only when every channel is one-shot.

Latency:
- en_low_i sampled 0 at edge n (IDLE): state=GEN, gen_en_o=1 after edge n.
- With div=0, addr_o=1 after edge n+1.
- en_low_i sampled 1 in GEN: all outputs 0 and addresses 0 after the same edge.

Simultaneous events and mid-operation reset:
- Config word for channel c written while other channels are paused: only c restarts from 0.
- rst asserted mid-GEN: full reset on that edge; no partial update.

Decomposition:
- Package funct_generator_pkg:
  - state_t enum {IDLE, CONFI, GEN, DONE} (logic [1:0]).
  - mode_t enum {MODE_CONT=0, MODE_ONESHOT=1}.
  - localparam defaults.
- Sub-module funct_generator_chan: prescaler, address counter, mode/div registers, wrap and done logic for one channel.
  - Inputs: clk, rst, run, cfg_we, cfg_div, cfg_mode, clr.
  - Instantiated NUM_CH times in a generate loop under the top-level FSM.

Test Plan:
1. Reset, then en_low_i=0, defaults (div=0, continuous), DEPTH=256 -> addr_o[0] counts 1..255,0. wrap_o[0] pulses once per 256 cycles; busy_o=1.
2. Configure ch1 div=3 one-shot, then en_low_i=0 -> ch1 address steps every 4 cycles and stops at 255 with done_o[1]=1. gen_en_o[1] falls next cycle; ch0 still counting; state stays GEN.
3. Configure both channels one-shot, div=0 -> both reach 255 at the same cycle, state DONE, gen_en_o=0. en_low_i=1 -> IDLE with addr_o=0 and done_o=0.
4. Mid-GEN (ch0 addr=40) send config for ch1 with conf_valid_i and en_low_i=0 both active -> CONFI, conf_ready_o=1, ch0 frozen at 40. On resume, ch0 continues at 41 and ch1 restarts at 0.
5. Two back-to-back config words (ch0 div=1, ch1 div=2) plus one with conf_ch_i=NUM_CH -> three cycles of ready, two channels updated, the invalid word is dropped.
6. rst=0 for one cycle during GEN at addr=100 -> next cycle all outputs 0, state IDLE, divs 0, modes continuous.
